// File: rtl/decoder3to8_stream.sv
`default_nettype none
// ============================================================================
// Module   : decoder3to8_stream
// Brief    : Streaming 3-to-8 decoder. Codes arrive over valid/ready, are
//            buffered in a small FIFO and each one drives a registered
//            one-hot output for a programmable dwell of dwell+1 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module decoder3to8_stream #(
   parameter int DEPTH   = 4,
   parameter int DWELL_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_code,
   input  logic [DWELL_W-1:0]       dwell,
   input  logic                     en,
   output logic [7:0]               Y,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_lvl_w = c_ptr_w + 1;
   localparam logic [c_lvl_w-1:0] c_full = c_lvl_w'(DEPTH);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   // FIFO storage and control
   logic [2:0]          r_mem [DEPTH];
   logic [c_ptr_w-1:0]  r_wptr;
   logic [c_ptr_w-1:0]  r_rptr;
   logic [c_lvl_w-1:0]  r_level;
   logic                r_ready;

   // Output sequencer
   state_t              r_state;
   logic [DWELL_W-1:0]  r_cnt;
   logic [7:0]          r_y;

   logic                w_push;
   logic                w_pop;
   logic                w_empty;
   logic [2:0]          w_head;
   logic [7:0]          w_onehot;
   logic [c_lvl_w-1:0]  w_level_nxt;
   state_t              w_state_nxt;
   logic [DWELL_W-1:0]  w_cnt_nxt;
   logic [7:0]          w_y_nxt;

   // in_ready is the registered not-full flag, so a full FIFO refuses a push
   // even on a cycle where a pop frees a slot.
   assign w_push  = in_valid & r_ready;
   assign w_empty = (r_level == '0);
   // A pop is allowed from IDLE, or at the last cycle of a hold so the next
   // code follows with no zero gap; a running hold ignores en.
   assign w_pop   = !w_empty && en &&
                    ((r_state == ST_IDLE) || (r_cnt == '0));
   assign w_head  = r_mem[r_rptr];

   // Two 2-to-4 decoders, each enabled by one value of code bit 2.
   for (genvar h = 0; h < 2; h++) begin : g_half
      assign w_onehot[4*h +: 4] = (w_head[2] == 1'(h)) ?
                                  (4'b0001 << w_head[1:0]) : 4'b0000;
   end

   // Occupancy after this edge's push and/or pop.
   always_comb begin
      w_level_nxt = r_level;
      case ({w_push, w_pop})
         2'b10:   w_level_nxt = r_level + 1'b1;
         2'b01:   w_level_nxt = r_level - 1'b1;
         default: w_level_nxt = r_level;
      endcase
   end

   // Data array; contents are don't-care once the pointers are reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= in_code;
      end
   end

   // FIFO pointers, occupancy and the registered ready flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_ready <= 1'b1;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_level <= w_level_nxt;
         r_ready <= (w_level_nxt != c_full);
      end
   end

   // Next-state, dwell counter and one-hot output selection.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_y_nxt     = r_y;
      case (r_state)
         ST_IDLE: begin
            if (w_pop) begin
               w_state_nxt = ST_HOLD;
               w_cnt_nxt   = dwell;
               w_y_nxt     = w_onehot;
            end else begin
               w_y_nxt     = '0;
            end
         end
         ST_HOLD: begin
            if (r_cnt != '0) begin
               w_cnt_nxt   = r_cnt - 1'b1;
            end else if (w_pop) begin
               w_cnt_nxt   = dwell;
               w_y_nxt     = w_onehot;
            end else begin
               w_state_nxt = ST_IDLE;
               w_y_nxt     = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_y_nxt     = '0;
         end
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_y     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_y     <= w_y_nxt;
      end
   end

   assign in_ready = r_ready;
   assign Y        = r_y;
   assign busy     = (r_state == ST_HOLD) || !w_empty;
   assign level    = r_level;

endmodule
`default_nettype wire

// File: doc/decoder3to8_stream.md
# decoder3to8_stream

Streaming 3-to-8 decoder, the receive-side counterpart of the team's 8-to-3 priority encoders. Accepts 3-bit codes over a valid/ready handshake, buffers them in a small FIFO, and drives the one-hot 8-bit output for a programmable dwell time per code. The one-hot output is built from two 2-to-4 decoders gated by code bit 2, the mirror of the encoder's two 4-to-2 halves. It sits between a code source, such as an encoder or link, and one-hot consumers such as LED, mux-select or strobe lines.

## Interface
- DEPTH, 4: FIFO depth in entries; power of 2, at least 2.
- DWELL_W, 4: width of the dwell input.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  FIFO can accept; equals not-full.
- in_code  input  3  code to decode; 0..7.
- dwell  input  DWELL_W  hold count; sampled at each pop, and Y holds for dwell+1 cycles.
- en  input  1  permits popping a new code; does not affect a hold already in progress.
- Y  output  8  registered one-hot output, or all-zero when idle.
- busy  output  1  high when the block is in HOLD or the FIFO is non-empty.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

## Operation
- Reset values:
  - Y=0, busy=0, level=0, in_ready=1.
  - FSM is in IDLE, the dwell counter is 0, and FIFO pointers are 0.
- Push:
  - A code is pushed when in_valid && in_ready at the clock edge.
  - in_ready is the registered not-full flag and does not depend on a same-cycle pop. When the FIFO is full, no push occurs even if a pop happens that cycle.
- Pop conditions: a pop occurs only when the FIFO is non-empty and en=1, and either:
  - the FSM is in IDLE, or
  - the FSM is in HOLD with the counter at 0.
- FSM states: IDLE and HOLD.
  - IDLE with a pop: Y <= onehot(code), cnt <= dwell, go to HOLD.
  - IDLE without a pop: Y stays 0.
  - HOLD with cnt != 0: cnt decrements; Y unchanged; en is ignored.
  - HOLD with cnt == 0 and a pop: load the next code and dwell back-to-back, with no zero gap; stay in HOLD.
  - HOLD with cnt == 0 and no pop (FIFO empty or en=0): Y <= 0, go to IDLE.
- One-hot encoding:
  - Y[3:0] = dec2(code[1:0]) when code[2]=0, else 0.
  - Y[7:4] = dec2(code[1:0]) when code[2]=1, else 0.
  - Exactly one bit of Y is set whenever the FSM is in HOLD.
- Level and simultaneous events:
  - On simultaneous push and pop, level is unchanged and data order is preserved (FIFO).
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Full is level==DEPTH; empty is level==0.
- Reset mid-operation: asserting rst forces all reset values immediately (asynchronously). Buffered codes are discarded and Y drops to 0 without waiting for the edge.

## Timing
- Latency from accept to Y:
  - A code accepted at edge k into an empty FIFO while IDLE with en=1 is popped at edge k+1.
  - Y is valid after edge k+1, so latency is 1 cycle.
- Hold length: each code drives Y for exactly dwell+1 cycles, counted from the edge that loads it.
- Back-to-back codes: consecutive codes with dwell=d produce a change of Y every d+1 cycles, with no idle cycle between them.
- Output timing: level and in_ready update at the edge after a push or pop. Y and busy are registered or derived only from registers; no combinational path runs from inputs to outputs.
- Changing dwell: a change during HOLD has no effect until the next pop.

## Test plan
- Reset, then push code 5 with dwell=0 and en=1: Y=8'h20 for exactly 1 cycle starting one edge after the accept, then Y=0; busy falls when Y returns to 0.
- Push codes 0..7 back-to-back with dwell=2: Y walks 01,02,04,...,80, each value held 3 cycles with no zero gaps; in_ready never drops below the pop rate.
- Hold en=0 and push 4 codes: level reaches 4 and in_ready=0; a 5th in_valid is not accepted. Raise en: codes emerge in order and in_ready rises one edge after the first pop.
- Drop en mid-hold with dwell=3: the current code still holds 4 cycles, then Y=0 and the FSM goes IDLE while the FIFO stays non-empty (busy=1).
- Assert rst asynchronously while Y=8'h08 and level=3: Y, level and busy go 0 immediately, in_ready=1; after release, the previously buffered codes never appear.
- Push while popping at level 2 for 10 cycles: level stays 2, and the output order matches the input order across pointer wrap-around.
